// File: rtl/alu_arbiter_if.sv
// Bundle of requester handshakes, response channel and ALU hookup for alu_arbiter.
// slave is the arbiter's view; master is the view of the surrounding requesters and ALU.
interface alu_arbiter_if #(
    parameter int WIDTH = 4,
    parameter int SEL_W = 3
);
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [WIDTH-1:0] req_a0;
    logic [WIDTH-1:0] req_b0;
    logic [SEL_W-1:0] req_sel0;
    logic [WIDTH-1:0] req_a1;
    logic [WIDTH-1:0] req_b1;
    logic [SEL_W-1:0] req_sel1;
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_carry;
    logic             rsp_borrow;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [SEL_W-1:0] alu_sel;
    logic [WIDTH-1:0] alu_result;
    logic             alu_carry;
    logic             alu_borrow;
    logic             busy;

    modport slave (
        input  req_valid, req_a0, req_b0, req_sel0, req_a1, req_b1, req_sel1,
        input  rsp_ready, alu_result, alu_carry, alu_borrow,
        output req_ready, rsp_valid, rsp_result, rsp_carry, rsp_borrow,
        output alu_a, alu_b, alu_sel, busy
    );

    modport master (
        output req_valid, req_a0, req_b0, req_sel0, req_a1, req_b1, req_sel1,
        output rsp_ready, alu_result, alu_carry, alu_borrow,
        input  req_ready, rsp_valid, rsp_result, rsp_carry, rsp_borrow,
        input  alu_a, alu_b, alu_sel, busy
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters;
// one operation in flight, sequenced IDLE -> EXEC -> RESP.
module alu_arbiter #(
    parameter int WIDTH = 4,
    parameter int SEL_W = 3
) (
    input  logic          clk,
    input  logic          rst,
    alu_arbiter_if.slave  bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]       state_r;
    logic             prio_r;
    logic             owner_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [SEL_W-1:0] sel_r;
    logic [WIDTH-1:0] result_r;
    logic             carry_r;
    logic             borrow_r;
    logic [1:0]       rsp_valid_r;
    logic             busy_r;
    logic [1:0]       gnt_s;
    logic             accept_s;
    logic             gidx_s;

    // Grant selection: only in IDLE, pointer breaks ties when both are valid.
    always_comb begin
        gnt_s = 2'b00;
        if (state_r == IDLE) begin
            case (bus.req_valid)
                2'b01:   gnt_s = 2'b01;
                2'b10:   gnt_s = 2'b10;
                2'b11:   gnt_s = prio_r ? 2'b10 : 2'b01;
                default: gnt_s = 2'b00;
            endcase
        end else begin
            gnt_s = 2'b00;
        end
    end

    assign accept_s = |gnt_s;
    assign gidx_s   = gnt_s[1];

    // Ready is combinational and masked while reset is asserted.
    always_comb begin
        if (rst) begin
            bus.req_ready = 2'b00;
        end else begin
            bus.req_ready = gnt_s;
        end
    end

    // Sequencer: operand capture on accept, ALU capture at end of EXEC, release on response accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            prio_r      <= 1'b0;
            owner_r     <= 1'b0;
            a_r         <= {WIDTH{1'b0}};
            b_r         <= {WIDTH{1'b0}};
            sel_r       <= {SEL_W{1'b0}};
            result_r    <= {WIDTH{1'b0}};
            carry_r     <= 1'b0;
            borrow_r    <= 1'b0;
            rsp_valid_r <= 2'b00;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        a_r     <= gidx_s ? bus.req_a1   : bus.req_a0;
                        b_r     <= gidx_s ? bus.req_b1   : bus.req_b0;
                        sel_r   <= gidx_s ? bus.req_sel1 : bus.req_sel0;
                        owner_r <= gidx_s;
                        prio_r  <= ~gidx_s;
                        busy_r  <= 1'b1;
                        state_r <= EXEC;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                EXEC: begin
                    result_r    <= bus.alu_result;
                    carry_r     <= bus.alu_carry;
                    borrow_r    <= bus.alu_borrow;
                    rsp_valid_r <= owner_r ? 2'b10 : 2'b01;
                    state_r     <= RESP;
                end
                RESP: begin
                    // The non-owner's rsp_ready has no effect here.
                    if (bus.rsp_ready[owner_r]) begin
                        rsp_valid_r <= 2'b00;
                        busy_r      <= 1'b0;
                        state_r     <= IDLE;
                    end else begin
                        state_r <= RESP;
                    end
                end
                default: begin
                    rsp_valid_r <= 2'b00;
                    busy_r      <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign bus.alu_a      = a_r;
    assign bus.alu_b      = b_r;
    assign bus.alu_sel    = sel_r;
    assign bus.rsp_valid  = rsp_valid_r;
    assign bus.rsp_result = result_r;
    assign bus.rsp_carry  = carry_r;
    assign bus.rsp_borrow = borrow_r;
    assign bus.busy       = busy_r;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small behavioural ALU attached to its ALU port.
module tb_alu_arbiter;
    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   cyc;
    int   last_acc;
    logic [4:0] alu_res;
    logic       alu_brw;

    alu_arbiter_if #(.WIDTH(4), .SEL_W(3)) bus ();

    alu_arbiter #(.WIDTH(4), .SEL_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference ALU: add, sub, and, or, xor, not, shift-left, add-with-carry-in.
    always_comb begin
        alu_res = 5'b00000;
        alu_brw = 1'b0;
        case (bus.alu_sel)
            3'b000: alu_res = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
            3'b001: begin
                alu_res = {1'b0, bus.alu_a - bus.alu_b};
                alu_brw = (bus.alu_a < bus.alu_b);
            end
            3'b010: alu_res = {1'b0, bus.alu_a & bus.alu_b};
            3'b011: alu_res = {1'b0, bus.alu_a | bus.alu_b};
            3'b100: alu_res = {1'b0, bus.alu_a ^ bus.alu_b};
            3'b101: alu_res = {1'b0, ~bus.alu_a};
            3'b110: alu_res = {bus.alu_a, 1'b0};
            3'b111: alu_res = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + 5'd1;
            default: alu_res = 5'b00000;
        endcase
    end

    assign bus.alu_result = alu_res[3:0];
    assign bus.alu_carry  = alu_res[4];
    assign bus.alu_borrow = alu_brw;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] sa [4];
    logic [3:0] sb [4];
    logic [2:0] ss [4];
    logic [3:0] sr [4];
    logic       sc [4];
    logic       sw [4];

    initial begin
        total = 0; bad = 0; cyc = 0; last_acc = 0;
        rst = 1'b1;
        bus.req_valid = 2'b00;
        bus.req_a0 = 4'd0; bus.req_b0 = 4'd0; bus.req_sel0 = 3'd0;
        bus.req_a1 = 4'd0; bus.req_b1 = 4'd0; bus.req_sel1 = 3'd0;
        bus.rsp_ready = 2'b11;
        sa = '{4'b0010, 4'b0111, 4'b1010, 4'b1001};
        sb = '{4'b0011, 4'b0010, 4'b0110, 4'b0001};
        ss = '{3'b000,  3'b001,  3'b100,  3'b110};
        sr = '{4'b0101, 4'b0101, 4'b1100, 4'b0010};
        sc = '{1'b0, 1'b0, 1'b0, 1'b1};
        sw = '{1'b0, 1'b0, 1'b0, 1'b0};
        tick(); tick();

        // reset state, ready masked while reset is high
        bus.req_valid = 2'b11;
        #1;
        check("rst_req_ready", 32'(bus.req_ready), 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        check("rst_alu_ops", 32'({bus.alu_a, bus.alu_b, bus.alu_sel}), 32'h0);
        check("rst_rsp", 32'({bus.rsp_result, bus.rsp_carry, bus.rsp_borrow}), 32'h0);
        bus.req_valid = 2'b00;
        rst = 1'b0;
        tick();

        // single add from requester 0
        bus.req_a0 = 4'b1101; bus.req_b0 = 4'b0110; bus.req_sel0 = 3'b000;
        bus.req_valid = 2'b01;
        #1;
        check("add_req_ready", 32'(bus.req_ready), 32'h1);
        tick();
        bus.req_valid = 2'b00;
        check("add_exec_busy", 32'(bus.busy), 32'h1);
        check("add_exec_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        check("add_exec_alu", 32'({bus.alu_a, bus.alu_b, bus.alu_sel}), 32'({4'b1101, 4'b0110, 3'b000}));
        tick();
        check("add_rsp_valid", 32'(bus.rsp_valid), 32'h1);
        check("add_rsp", 32'({bus.rsp_result, bus.rsp_carry, bus.rsp_borrow}), 32'({4'b0011, 1'b1, 1'b0}));
        tick();
        check("add_busy_fall", 32'(bus.busy), 32'h0);
        check("add_rsp_clear", 32'(bus.rsp_valid), 32'h0);

        // reset mid-EXEC; pointer now favours requester 1
        bus.req_a0 = 4'b0010; bus.req_b0 = 4'b0100; bus.req_sel0 = 3'b000;
        bus.req_a1 = 4'b0011; bus.req_b1 = 4'b1001; bus.req_sel1 = 3'b001;
        bus.req_valid = 2'b11;
        #1;
        check("rr_after_add", 32'(bus.req_ready), 32'h2);
        tick();
        check("mid_exec_alu_a", 32'(bus.alu_a), 32'h3);
        rst = 1'b1;
        #1;
        check("midrst_busy", 32'(bus.busy), 32'h0);
        check("midrst_alu_ops", 32'({bus.alu_a, bus.alu_b, bus.alu_sel}), 32'h0);
        check("midrst_rsp", 32'({bus.rsp_result, bus.rsp_carry, bus.rsp_borrow}), 32'h0);
        check("midrst_valid_ready", 32'({bus.rsp_valid, bus.req_ready}), 32'h0);
        tick();
        rst = 1'b0;
        #1;
        check("post_rst_grant0", 32'(bus.req_ready), 32'h1);

        // contention: grants alternate 0,1,0,1
        for (int i = 0; i < 4; i++) begin
            logic g;
            g = i[0];
            check("cont_ready", 32'(bus.req_ready), g ? 32'h2 : 32'h1);
            tick();
            check("cont_alu_a", 32'(bus.alu_a), g ? 32'h3 : 32'h2);
            tick();
            check("cont_rsp_valid", 32'(bus.rsp_valid), g ? 32'h2 : 32'h1);
            check("cont_rsp", 32'({bus.rsp_result, bus.rsp_carry, bus.rsp_borrow}),
                  g ? 32'({4'b1010, 1'b0, 1'b1}) : 32'({4'b0110, 1'b0, 1'b0}));
            tick();
        end

        // backpressure: owner 0 stalls, non-owner ready ignored, requester 1 waits
        bus.req_valid = 2'b01;
        bus.req_a0 = 4'b0101; bus.req_b0 = 4'b1100; bus.req_sel0 = 3'b010;
        bus.rsp_ready = 2'b10;
        #1;
        check("bp_ready", 32'(bus.req_ready), 32'h1);
        tick();
        bus.req_valid = 2'b10;
        bus.req_a1 = sa[0]; bus.req_b1 = sb[0]; bus.req_sel1 = ss[0];
        tick();
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_valid", 32'(bus.rsp_valid), 32'h1);
            check("bp_hold_rsp", 32'({bus.rsp_result, bus.rsp_carry, bus.rsp_borrow}), 32'({4'b0100, 1'b0, 1'b0}));
            check("bp_req_ready", 32'(bus.req_ready), 32'h0);
            tick();
        end
        bus.rsp_ready = 2'b01;
        tick();
        check("bp_done", 32'({bus.busy, bus.rsp_valid}), 32'h0);
        bus.rsp_ready = 2'b11;

        // lone requester 1 streaming at 3-cycle spacing
        for (int i = 0; i < 4; i++) begin
            bus.req_a1 = sa[i]; bus.req_b1 = sb[i]; bus.req_sel1 = ss[i];
            #1;
            check("stream_ready", 32'(bus.req_ready), 32'h2);
            tick();
            if (i > 0) check("stream_spacing", 32'(cyc - last_acc), 32'd3);
            last_acc = cyc;
            tick();
            check("stream_rsp_valid", 32'(bus.rsp_valid), 32'h2);
            check("stream_rsp", 32'({bus.rsp_result, bus.rsp_carry, bus.rsp_borrow}), 32'({sr[i], sc[i], sw[i]}));
            tick();
        end

        // opcode pass-through with sel=111
        bus.req_a1 = 4'b1111; bus.req_b1 = 4'b1111; bus.req_sel1 = 3'b111;
        #1;
        check("pt_ready", 32'(bus.req_ready), 32'h2);
        tick();
        bus.req_valid = 2'b00;
        check("pt_alu_ops", 32'({bus.alu_a, bus.alu_b, bus.alu_sel}), 32'({4'b1111, 4'b1111, 3'b111}));
        tick();
        check("pt_rsp", 32'({bus.rsp_valid, bus.rsp_result, bus.rsp_carry, bus.rsp_borrow}),
              32'({2'b10, 4'b1111, 1'b1, 1'b0}));
        tick();
        check("pt_idle", 32'(bus.busy), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
